// File: rtl/rs_issue_sched_pkg.sv
// Shared widths, op encodings and entry layout for the RS issue scheduler.
// RS_RR_ARB_EN selects round-robin issue instead of fixed priority.
package rs_issue_sched_pkg;

    localparam int INS_OP_W    = 4;
    localparam int REG_DAT_W   = 32;
    localparam int ROB_ADD_W   = 4;
    localparam int RS_SIZE_DEF = 16;

    localparam logic [INS_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [INS_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [INS_OP_W-1:0] OP_ADDI = 4'd2;
    localparam logic [INS_OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [INS_OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [INS_OP_W-1:0] OP_BEQ  = 4'd5;
    localparam logic [INS_OP_W-1:0] OP_BNE  = 4'd6;
    localparam logic [INS_OP_W-1:0] OP_JAL  = 4'd7;
    localparam logic [INS_OP_W-1:0] OP_JALR = 4'd8;

    typedef struct packed {
        logic                 busy;
        logic [INS_OP_W-1:0]  op;
        logic [REG_DAT_W-1:0] pc;
        logic [REG_DAT_W-1:0] imm;
        logic                 rdy1;
        logic [ROB_ADD_W-1:0] qs1;
        logic [REG_DAT_W-1:0] vs1;
        logic                 rdy2;
        logic [ROB_ADD_W-1:0] qs2;
        logic [REG_DAT_W-1:0] vs2;
        logic [ROB_ADD_W-1:0] qd;
    } rs_entry_t;

    typedef struct packed {
        logic                 en;
        logic [INS_OP_W-1:0]  op;
        logic [REG_DAT_W-1:0] pc;
        logic [REG_DAT_W-1:0] imm;
        logic [REG_DAT_W-1:0] vs1;
        logic [REG_DAT_W-1:0] vs2;
        logic [ROB_ADD_W-1:0] qd;
    } ex_iss_t;

    function automatic logic cdb_hit(
        input logic                 rdy,
        input logic [ROB_ADD_W-1:0] qs,
        input logic                 cdb_en,
        input logic [ROB_ADD_W-1:0] cdb_qd
    );
        return !rdy && cdb_en && (qs == cdb_qd);
    endfunction

endpackage

// File: rtl/rs_issue_sched_pick_arb.sv
// First-set search over a request vector, starting at base_i with wrap.
// Used for both free-slot pick and issue pick.
module rs_pick_arb #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] base_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [IDX_W-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = base_i + i[IDX_W-1:0];
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                idx_o    = j;
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation station for the integer EX unit: dispatch, CDB wake-up, issue.
// Define RS_RR_ARB_EN for round-robin issue; default is lowest-index-first.
module rs_issue_sched
    import rs_issue_sched_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iROB_Clear,
    input  logic                 iDsp_En,
    input  logic [INS_OP_W-1:0]  iDsp_Op,
    input  logic [REG_DAT_W-1:0] iDsp_Pc,
    input  logic [REG_DAT_W-1:0] iDsp_Imm,
    input  logic                 iDsp_Rdy1,
    input  logic [ROB_ADD_W-1:0] iDsp_Qs1,
    input  logic [REG_DAT_W-1:0] iDsp_Vs1,
    input  logic                 iDsp_Rdy2,
    input  logic [ROB_ADD_W-1:0] iDsp_Qs2,
    input  logic [REG_DAT_W-1:0] iDsp_Vs2,
    input  logic [ROB_ADD_W-1:0] iDsp_Qd,
    output logic                 oDsp_Full,
    input  logic                 iCdb_En,
    input  logic [ROB_ADD_W-1:0] iCdb_Qd,
    input  logic [REG_DAT_W-1:0] iCdb_Vd,
    output logic                 oEX_En,
    output logic [INS_OP_W-1:0]  oEX_Op,
    output logic [REG_DAT_W-1:0] oEX_Pc,
    output logic [REG_DAT_W-1:0] oEX_Imm,
    output logic [REG_DAT_W-1:0] oEX_Vs1,
    output logic [REG_DAT_W-1:0] oEX_Vs2,
    output logic [ROB_ADD_W-1:0] oEX_Qd
);

    rs_entry_t rs_q [RS_SIZE];
    rs_entry_t rs_d [RS_SIZE];
    ex_iss_t   ex_q, ex_d;

    logic [RS_SIZE-1:0]  busy, rdy;
    logic [RS_SIZE-1:0]  free_gnt, iss_gnt;
    logic [RS_IDX_W-1:0] free_idx_unused, iss_idx, iss_base;
    logic                free_vld, iss_vld, dsp_ok;
    logic                hit1, hit2;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i] = rs_q[i].busy;
            rdy[i]  = rs_q[i].busy & rs_q[i].rdy1 & rs_q[i].rdy2;
        end
    end

    assign oDsp_Full = &busy;
    assign dsp_ok    = iDsp_En & free_vld;

`ifdef RS_RR_ARB_EN
    logic [RS_IDX_W-1:0] ptr_q, ptr_d;

    assign iss_base = ptr_q;
    assign ptr_d    = iss_vld ? iss_idx + RS_IDX_W'(1) : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en && !iROB_Clear) begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign iss_base = '0;
`endif

    rs_pick_arb #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
        .req_i  (~busy),
        .base_i ('0),
        .gnt_o  (free_gnt),
        .idx_o  (free_idx_unused),
        .vld_o  (free_vld)
    );

    rs_pick_arb #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_iss_pick (
        .req_i  (rdy),
        .base_i (iss_base),
        .gnt_o  (iss_gnt),
        .idx_o  (iss_idx),
        .vld_o  (iss_vld)
    );

    assign hit1 = cdb_hit(iDsp_Rdy1, iDsp_Qs1, iCdb_En, iCdb_Qd);
    assign hit2 = cdb_hit(iDsp_Rdy2, iDsp_Qs2, iCdb_En, iCdb_Qd);

    always_comb begin
        rs_d = rs_q;
        ex_d = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (rs_q[i].busy && cdb_hit(rs_q[i].rdy1, rs_q[i].qs1, iCdb_En, iCdb_Qd)) begin
                rs_d[i].rdy1 = 1'b1;
                rs_d[i].vs1  = iCdb_Vd;
            end
            if (rs_q[i].busy && cdb_hit(rs_q[i].rdy2, rs_q[i].qs2, iCdb_En, iCdb_Qd)) begin
                rs_d[i].rdy2 = 1'b1;
                rs_d[i].vs2  = iCdb_Vd;
            end
            if (iss_gnt[i]) begin
                rs_d[i].busy = 1'b0;
            end
            // Issue and dispatch never collide: one picks busy, the other free.
            if (dsp_ok && free_gnt[i]) begin
                rs_d[i].busy = 1'b1;
                rs_d[i].op   = iDsp_Op;
                rs_d[i].pc   = iDsp_Pc;
                rs_d[i].imm  = iDsp_Imm;
                rs_d[i].qs1  = iDsp_Qs1;
                rs_d[i].qs2  = iDsp_Qs2;
                rs_d[i].qd   = iDsp_Qd;
                rs_d[i].rdy1 = iDsp_Rdy1 | hit1;
                rs_d[i].rdy2 = iDsp_Rdy2 | hit2;
                rs_d[i].vs1  = hit1 ? iCdb_Vd : iDsp_Vs1;
                rs_d[i].vs2  = hit2 ? iCdb_Vd : iDsp_Vs2;
            end
        end
        if (iss_vld) begin
            ex_d.en  = 1'b1;
            ex_d.op  = rs_q[iss_idx].op;
            ex_d.pc  = rs_q[iss_idx].pc;
            ex_d.imm = rs_q[iss_idx].imm;
            ex_d.vs1 = rs_q[iss_idx].vs1;
            ex_d.vs2 = rs_q[iss_idx].vs2;
            ex_d.qd  = rs_q[iss_idx].qd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_q[i] <= '0;
            end
            ex_q <= '0;
        end else if (en) begin
            if (iROB_Clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    rs_q[i].busy <= 1'b0;
                end
                ex_q <= '0;
            end else begin
                rs_q <= rs_d;
                ex_q <= ex_d;
            end
        end
    end

    assign oEX_En  = ex_q.en;
    assign oEX_Op  = ex_q.op;
    assign oEX_Pc  = ex_q.pc;
    assign oEX_Imm = ex_q.imm;
    assign oEX_Vs1 = ex_q.vs1;
    assign oEX_Vs2 = ex_q.vs2;
    assign oEX_Qd  = ex_q.qd;

endmodule
